hx8357_rect_fill: RTL and testbench

// Upstream command source for the HX8357 control stage. Accepts one rectangle-fill request and

---
 rtl/hx8357_rect_fill.sv | 178 +++++++++++++++++
 tb/tb_hx8357_rect_fill.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hx8357_rect_fill.sv
// Rectangle-fill command source for the HX8357 control stage.
// Emits CASET/PASET/RAMWR plus one RGB565 word per pixel, one word in flight at a time.
module hx8357_rect_fill #(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 480
) (
    input  logic        clk,
    input  logic        nres,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] data_lines,
    output logic        cmd,
    output logic        data,
    input  logic        transmission_cmpl
);

    localparam int unsigned CW = 9;
    localparam int unsigned PW = 18;
    localparam int unsigned IW = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Word index 0..10 walks the setup words; IDX_PIX marks the pixel phase.
    localparam logic [IW-1:0] IDX_PIX = 4'd11;
    localparam logic [CW-1:0] X_MAX   = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_MAX   = CW'(V_RES - 1);

    logic [1:0]    r_state;
    logic          r_busy, r_done, r_err, r_cmd, r_data;
    logic [15:0]   r_lines;
    logic [IW-1:0] r_idx;
    logic [PW-1:0] r_pix;
    logic [CW-1:0] r_x0, r_x1, r_y0, r_y1;
    logic [15:0]   r_color;

    logic [1:0]    w_state_nxt;
    logic          w_busy_nxt, w_done_nxt, w_err_nxt, w_cmd_nxt, w_data_nxt;
    logic [15:0]   w_lines_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [PW-1:0] w_pix_nxt;
    logic          w_accept;
    logic          w_bad;
    logic [9:0]    w_width, w_height;
    logic [PW-1:0] w_npix;
    logic [IW-1:0] w_sel;
    logic [15:0]   w_word;
    logic          w_sel_cmd;

    assign w_bad    = (x1 < x0) || (y1 < y0) || (x1 > X_MAX) || (y1 > Y_MAX);
    assign w_width  = 10'(x1) - 10'(x0) + 10'd1;
    assign w_height = 10'(y1) - 10'(y0) + 10'd1;
    assign w_npix   = PW'(w_width) * PW'(w_height);

    // Next word to issue after the one currently in flight.
    assign w_sel     = (r_idx == IDX_PIX) ? IDX_PIX : r_idx + 4'd1;
    assign w_sel_cmd = (w_sel == 4'd5) || (w_sel == 4'd10);

    always_comb begin
        w_word = r_color;
        case (w_sel)
            4'd0:    w_word = 16'h002A;
            4'd1:    w_word = {15'd0, r_x0[8]};
            4'd2:    w_word = {8'd0, r_x0[7:0]};
            4'd3:    w_word = {15'd0, r_x1[8]};
            4'd4:    w_word = {8'd0, r_x1[7:0]};
            4'd5:    w_word = 16'h002B;
            4'd6:    w_word = {15'd0, r_y0[8]};
            4'd7:    w_word = {8'd0, r_y0[7:0]};
            4'd8:    w_word = {15'd0, r_y1[8]};
            4'd9:    w_word = {8'd0, r_y1[7:0]};
            4'd10:   w_word = 16'h002C;
            default: w_word = r_color;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cmd_nxt   = 1'b0;
        w_data_nxt  = 1'b0;
        w_lines_nxt = r_lines;
        w_idx_nxt   = r_idx;
        w_pix_nxt   = r_pix;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_ISSUE;
                        w_busy_nxt  = 1'b1;
                        w_cmd_nxt   = 1'b1;
                        w_lines_nxt = 16'h002A;
                        w_idx_nxt   = 4'd0;
                        w_pix_nxt   = w_npix;
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (transmission_cmpl) begin
                    if ((r_idx == IDX_PIX) && (r_pix == '0)) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_idx_nxt   = w_sel;
                        w_lines_nxt = w_word;
                        w_cmd_nxt   = w_sel_cmd;
                        w_data_nxt  = !w_sel_cmd;
                        if (w_sel == IDX_PIX) w_pix_nxt = r_pix - PW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nres) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cmd   <= 1'b0;
            r_data  <= 1'b0;
            r_lines <= '0;
            r_idx   <= '0;
            r_pix   <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_cmd   <= w_cmd_nxt;
            r_data  <= w_data_nxt;
            r_lines <= w_lines_nxt;
            r_idx   <= w_idx_nxt;
            r_pix   <= w_pix_nxt;
            if (w_accept) begin
                r_x0    <= x0;
                r_x1    <= x1;
                r_y0    <= y0;
                r_y1    <= y1;
                r_color <= color;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cmd        = r_cmd;
    assign data       = r_data;
    assign data_lines = r_lines;

endmodule

// File: tb/tb_hx8357_rect_fill.sv
// Bench for hx8357_rect_fill: a control-stage responder with random completion delay,
// checked against a word-list model built from the rectangle coordinates.
module tb_hx8357_rect_fill;

    logic        clk = 1'b0;
    logic        nres;
    logic        start;
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color;
    logic        busy, done, err, cmd, data;
    logic [15:0] data_lines;
    logic        transmission_cmpl;

    int checks = 0;
    int errors = 0;
    logic [16:0] expq[$];

    always #5 clk = ~clk;

    hx8357_rect_fill dut (
        .clk(clk), .nres(nres), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .busy(busy), .done(done), .err(err),
        .data_lines(data_lines), .cmd(cmd), .data(data),
        .transmission_cmpl(transmission_cmpl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected word list: {is_cmd, value}.
    task automatic build_exp(input int a0, a1, b0, b1, input logic [15:0] col);
        int n;
        expq.delete();
        expq.push_back({1'b1, 16'h002A});
        expq.push_back({1'b0, 16'(a0 / 256)});
        expq.push_back({1'b0, 16'(a0 % 256)});
        expq.push_back({1'b0, 16'(a1 / 256)});
        expq.push_back({1'b0, 16'(a1 % 256)});
        expq.push_back({1'b1, 16'h002B});
        expq.push_back({1'b0, 16'(b0 / 256)});
        expq.push_back({1'b0, 16'(b0 % 256)});
        expq.push_back({1'b0, 16'(b1 / 256)});
        expq.push_back({1'b0, 16'(b1 % 256)});
        expq.push_back({1'b1, 16'h002C});
        n = (a1 - a0 + 1) * (b1 - b0 + 1);
        for (int i = 0; i < n; i++) expq.push_back({1'b0, col});
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, "_strobe"}, {30'd0, cmd, data}, 32'd0);
            chk({tag, "_done"}, {31'd0, done}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_cmd"}, {31'd0, cmd}, 32'd0);
        chk({tag, "_data"}, {31'd0, data}, 32'd0);
        chk({tag, "_lines"}, {16'd0, data_lines}, 32'd0);
    endtask

    // Issue one request and act as the control stage until done (or abort by reset).
    task automatic run_req(input int a0, a1, b0, b1, input logic [15:0] col,
                           input bit hammer, input int abort_at, input bit spurious);
        int k, wt, cyc, budget;
        bit outst, expect_next, fin, aborted;
        logic [15:0] hold;
        build_exp(a0, a1, b0, b1, col);
        budget = expq.size() * 6 + 20;
        @(negedge clk);
        start = 1'b1;
        x0 = 9'(a0); x1 = 9'(a1); y0 = 9'(b0); y1 = 9'(b1); color = col;
        transmission_cmpl = spurious;
        @(negedge clk);
        if (!hammer) start = 1'b0;
        k = 0; wt = 0; cyc = 0; outst = 0; expect_next = 1; fin = 0; aborted = 0; hold = '0;
        while (!fin) begin
            transmission_cmpl = 1'b0;
            chk("cmd_data_exclusive", {31'd0, cmd & data}, 32'd0);
            if (expect_next) begin
                if (k < expq.size()) chk("strobe_latency", {31'd0, cmd | data}, 32'd1);
                else chk("done_latency", {31'd0, done}, 32'd1);
                expect_next = 0;
            end
            if (done) begin
                chk("word_count", k, expq.size());
                chk("busy_in_done", {31'd0, busy}, 32'd0);
                chk("err_in_run", {31'd0, err}, 32'd0);
                fin = 1;
                if (hammer) begin
                    x0 = 9'd1; x1 = 9'd2; y0 = 9'd3; y1 = 9'd4;
                end
            end else if (cmd | data) begin
                chk("one_outstanding", {31'd0, outst}, 32'd0);
                chk("busy_at_strobe", {31'd0, busy}, 32'd1);
                if (k < expq.size()) chk("word", {15'd0, cmd, data_lines}, {15'd0, expq[k]});
                else chk("extra_strobe", 32'd1, 32'd0);
                hold = data_lines;
                k++;
                outst = 1;
                wt = $urandom_range(0, 2);
                if (spurious) transmission_cmpl = 1'b1;
            end else if (outst) begin
                chk("lines_hold", {16'd0, data_lines}, {16'd0, hold});
                chk("busy_in_wait", {31'd0, busy}, 32'd1);
                if (abort_at >= 0 && k == abort_at) begin
                    nres = 1'b0;
                    aborted = 1;
                    fin = 1;
                end else if (wt == 0) begin
                    transmission_cmpl = 1'b1;
                    outst = 0;
                    expect_next = 1;
                end else begin
                    wt--;
                end
            end
            if (hammer && !fin) begin
                x0 = 9'($urandom_range(0, 319)); x1 = 9'($urandom_range(0, 319));
                y0 = 9'($urandom_range(0, 479)); y1 = 9'($urandom_range(0, 479));
            end
            cyc++;
            if (cyc > budget) begin
                chk("timeout", 32'd0, 32'd1);
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        if (aborted) begin
            @(negedge clk);
            nres = 1'b1;
            check_reset_outputs("reset_mid");
            check_quiet("after_reset", 5);
        end else if (hammer) begin
            @(negedge clk);
            chk("b2b_idle_gap", {31'd0, cmd}, 32'd0);
            @(negedge clk);
            start = 1'b0;
            chk("b2b_cmd", {15'd0, cmd, data_lines}, {15'd0, 1'b1, 16'h002A});
            nres = 1'b0;
            @(negedge clk);
            nres = 1'b1;
            check_reset_outputs("b2b_reset");
        end
    endtask

    task automatic reject(input int a0, a1, b0, b1, input string tag);
        @(negedge clk);
        start = 1'b1;
        x0 = 9'(a0); x1 = 9'(a1); y0 = 9'(b0); y1 = 9'(b1); color = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_strobe"}, {30'd0, cmd, data}, 32'd0);
        @(negedge clk);
        chk({tag, "_err_pulse"}, {31'd0, err}, 32'd0);
        chk({tag, "_busy2"}, {31'd0, busy}, 32'd0);
        check_quiet(tag, 3);
    endtask

    initial begin
        int a0, a1, b0, b1;
        nres = 1'b0; start = 1'b0; transmission_cmpl = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        nres = 1'b1;

        // Spurious completions while idle must not start anything.
        transmission_cmpl = 1'b1;
        check_quiet("idle_cmpl", 3);
        transmission_cmpl = 1'b0;

        run_req(5, 5, 7, 7, 16'h07E0, 0, -1, 1);
        run_req(0, 1, 0, 1, 16'h1234, 0, -1, 0);
        run_req(319, 319, 479, 479, 16'hABCD, 0, -1, 1);
        run_req(255, 257, 254, 256, 16'h5A5A, 0, -1, 0);
        for (int t = 0; t < 4; t++) begin
            a0 = $urandom_range(0, 319); a1 = a0 + $urandom_range(0, 5);
            if (a1 > 319) a1 = 319;
            b0 = $urandom_range(0, 479); b1 = b0 + $urandom_range(0, 5);
            if (b1 > 479) b1 = 479;
            run_req(a0, a1, b0, b1, 16'($urandom), 0, -1, t[0]);
        end

        reject(10, 9, 0, 0, "rej_x");
        reject(0, 0, 0, 480, "rej_ymax");
        reject(0, 320, 0, 0, "rej_xmax");
        reject(0, 0, 8, 7, "rej_y");

        run_req(0, 1, 0, 1, 16'h00FF, 1, -1, 0);

        // Reset while waiting on pixel 100 of 200, then a clean restart.
        run_req(0, 19, 0, 9, 16'h0F0F, 0, 111, 0);
        run_req(2, 3, 4, 4, 16'hC0DE, 0, -1, 1);

        // Full screen: setup words and first pixels, then abandoned by reset.
        run_req(0, 319, 0, 479, 16'hF800, 0, 16, 0);
        run_req(5, 5, 7, 7, 16'h07E0, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
